stage_sequencer: RTL and testbench

//  Parametrised generator of the per-stage enables (fetch, decode, execute, memory, writeback, ...)

---
 rtl/stage_sequencer_if.sv | 24 ++
 rtl/stage_sequencer.sv | 88 ++++++++
 tb/tb_stage_sequencer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/stage_sequencer_if.sv
// rtl/stage_sequencer_if.sv - control/status bundle between top-level control and the stage sequencer
interface stage_sequencer_if #(
  parameter int NUM_STAGES = 5,
  parameter int CNT_W      = 32
) ();
  logic                  run;
  logic                  stall;
  logic                  flush;
  logic [NUM_STAGES-1:0] skip_mask;
  logic [NUM_STAGES-1:0] stage_en;
  logic                  retire;
  logic                  busy;
  logic [CNT_W-1:0]      instr_count;

  modport master (
    output run, stall, flush, skip_mask,
    input  stage_en, retire, busy, instr_count
  );

  modport slave (
    input  run, stall, flush, skip_mask,
    output stage_en, retire, busy, instr_count
  );
endinterface

// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - per-stage enable generator for the netpath datapath
// MODE 0 walks a one-hot token through the stages; MODE 1 shifts valid bits like a pipeline.
module stage_sequencer #(
  parameter int NUM_STAGES = 5,
  parameter int MODE       = 0,
  parameter int CNT_W      = 32
) (
  input logic              clk,
  input logic              rst,
  stage_sequencer_if.slave bus
);
  localparam int LAST = NUM_STAGES - 1;
  localparam logic [NUM_STAGES-1:0] FETCH = NUM_STAGES'(1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e                state_q;
  logic [NUM_STAGES-1:0] stage_en_q;
  logic [NUM_STAGES-1:0] token_adv_d;
  logic [CNT_W-1:0]      instr_count_q;
  logic                  retire;

  // Next token: first stage above the current one that is not skipped; the last stage is never skipped.
  always_comb begin
    logic seen;
    logic found;
    token_adv_d = '0;
    seen        = 1'b0;
    found       = 1'b0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (seen && !found && (k == LAST || !bus.skip_mask[k])) begin
        token_adv_d[k] = 1'b1;
        found          = 1'b1;
      end
      if (stage_en_q[k]) begin
        seen = 1'b1;
      end
    end
  end

  assign retire = stage_en_q[LAST] & ~bus.stall & ~bus.flush & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      stage_en_q    <= '0;
      instr_count_q <= '0;
    end else begin
      if (retire) begin
        instr_count_q <= instr_count_q + CNT_W'(1);
      end
      if (MODE == 0) begin
        case (state_q)
          IDLE: begin
            if (bus.run) begin
              state_q    <= RUN;
              stage_en_q <= FETCH;
            end
          end
          RUN: begin
            // Flush and completion both restart at fetch, or park in IDLE when run is low.
            if (bus.flush || (!bus.stall && stage_en_q[LAST])) begin
              if (bus.run) begin
                stage_en_q <= FETCH;
              end else begin
                state_q    <= IDLE;
                stage_en_q <= '0;
              end
            end else if (!bus.stall) begin
              stage_en_q <= token_adv_d;
            end
          end
        endcase
      end else begin
        if (bus.flush) begin
          stage_en_q <= '0;
        end else if (!bus.stall) begin
          stage_en_q <= {stage_en_q[LAST-1:0], bus.run};
        end
      end
    end
  end

  assign bus.stage_en    = stage_en_q;
  assign bus.retire      = retire;
  assign bus.busy        = |stage_en_q;
  assign bus.instr_count = instr_count_q;
endmodule

// File: tb/tb_stage_sequencer.sv
// tb/tb_stage_sequencer.sv - directed table-driven bench for both sequencer modes
module tb_stage_sequencer;
  logic clk;
  logic rst;

  stage_sequencer_if #(.NUM_STAGES(5), .CNT_W(4))  if0 ();
  stage_sequencer_if #(.NUM_STAGES(5), .CNT_W(32)) if1 ();

  stage_sequencer #(.NUM_STAGES(5), .MODE(0), .CNT_W(4))  dut0 (.clk(clk), .rst(rst), .bus(if0));
  stage_sequencer #(.NUM_STAGES(5), .MODE(1), .CNT_W(32)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        run;
    logic        stall;
    logic        flush;
    logic [4:0]  skip;
    logic [4:0]  en;
    logic        ret;
    logic [31:0] cnt;
  } vec_t;

  vec_t tab0[$];
  vec_t tab1[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic r, logic s, logic f, logic [4:0] sk, logic [4:0] e, logic rt, int c);
    vec_t v;
    v.run = r; v.stall = s; v.flush = f; v.skip = sk;
    v.en = e; v.ret = rt; v.cnt = c;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int which, input logic r, input logic s, input logic f, input logic [4:0] sk);
    if (which == 0) begin
      if0.run = r; if0.stall = s; if0.flush = f; if0.skip_mask = sk;
    end else begin
      if1.run = r; if1.stall = s; if1.flush = f; if1.skip_mask = sk;
    end
  endtask

  task automatic observe(input int which, input string tag, input logic [4:0] en, input logic ret, input logic [31:0] cnt);
    logic [4:0]  a_en;
    logic        a_ret;
    logic        a_busy;
    logic [31:0] a_cnt;
    if (which == 0) begin
      a_en = if0.stage_en; a_ret = if0.retire; a_busy = if0.busy; a_cnt = {28'd0, if0.instr_count};
    end else begin
      a_en = if1.stage_en; a_ret = if1.retire; a_busy = if1.busy; a_cnt = if1.instr_count;
    end
    chk({tag, " stage_en"}, {27'd0, a_en}, {27'd0, en});
    chk({tag, " retire"}, {31'd0, a_ret}, {31'd0, ret});
    chk({tag, " busy"}, {31'd0, a_busy}, {31'd0, (en != 5'd0)});
    chk({tag, " count"}, a_cnt, cnt);
  endtask

  task automatic run_table(input int which);
    vec_t v;
    int   n;
    n = (which == 0) ? tab0.size() : tab1.size();
    for (int i = 0; i < n; i++) begin
      v = (which == 0) ? tab0[i] : tab1[i];
      drive(which, v.run, v.stall, v.flush, v.skip);
      #2;
      observe(which, $sformatf("m%0d row%0d", which, i), v.en, v.ret, v.cnt);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // MODE 0: normal flow, stall, skip, idle, flush, run drop
    tab0.push_back(mk(1,0,0,5'b00000, 5'b00000,0,0));
    tab0.push_back(mk(1,0,0,5'b00000, 5'b00001,0,0));
    tab0.push_back(mk(1,0,0,5'b00000, 5'b00010,0,0));
    tab0.push_back(mk(1,0,0,5'b00000, 5'b00100,0,0));
    tab0.push_back(mk(1,0,0,5'b00000, 5'b01000,0,0));
    tab0.push_back(mk(1,0,0,5'b00000, 5'b10000,1,0));
    tab0.push_back(mk(1,0,0,5'b00000, 5'b00001,0,1));
    tab0.push_back(mk(1,1,0,5'b00000, 5'b00010,0,1));
    tab0.push_back(mk(1,1,0,5'b00000, 5'b00010,0,1));
    tab0.push_back(mk(1,1,0,5'b00000, 5'b00010,0,1));
    tab0.push_back(mk(1,0,0,5'b00000, 5'b00010,0,1));
    tab0.push_back(mk(1,0,0,5'b00000, 5'b00100,0,1));
    tab0.push_back(mk(1,0,0,5'b00000, 5'b01000,0,1));
    tab0.push_back(mk(1,1,0,5'b00000, 5'b10000,0,1));
    tab0.push_back(mk(1,0,0,5'b00000, 5'b10000,1,1));
    tab0.push_back(mk(1,0,0,5'b01000, 5'b00001,0,2));
    tab0.push_back(mk(1,0,0,5'b01000, 5'b00010,0,2));
    tab0.push_back(mk(1,0,0,5'b01000, 5'b00100,0,2));
    tab0.push_back(mk(1,0,0,5'b01000, 5'b10000,1,2));
    tab0.push_back(mk(1,0,0,5'b01110, 5'b00001,0,3));
    tab0.push_back(mk(1,0,0,5'b11111, 5'b10000,1,3));
    tab0.push_back(mk(1,0,0,5'b11111, 5'b00001,0,4));
    tab0.push_back(mk(0,0,0,5'b00000, 5'b10000,1,4));
    tab0.push_back(mk(0,0,0,5'b00000, 5'b00000,0,5));
    tab0.push_back(mk(1,1,1,5'b00000, 5'b00000,0,5));
    tab0.push_back(mk(1,0,0,5'b00000, 5'b00001,0,5));
    tab0.push_back(mk(1,0,0,5'b00000, 5'b00010,0,5));
    tab0.push_back(mk(1,0,1,5'b00000, 5'b00100,0,5));
    tab0.push_back(mk(1,0,0,5'b00000, 5'b00001,0,5));
    tab0.push_back(mk(1,0,0,5'b00000, 5'b00010,0,5));
    tab0.push_back(mk(0,0,1,5'b00000, 5'b00100,0,5));
    tab0.push_back(mk(0,0,0,5'b00000, 5'b00000,0,5));
    tab0.push_back(mk(1,0,0,5'b01110, 5'b00000,0,5));
    tab0.push_back(mk(1,0,0,5'b01110, 5'b00001,0,5));
    tab0.push_back(mk(1,1,1,5'b01110, 5'b10000,0,5));
    tab0.push_back(mk(0,0,0,5'b00000, 5'b00001,0,5));
    tab0.push_back(mk(0,0,0,5'b00000, 5'b00010,0,5));
    tab0.push_back(mk(0,0,0,5'b00000, 5'b00100,0,5));
    tab0.push_back(mk(0,0,0,5'b00000, 5'b01000,0,5));
    tab0.push_back(mk(0,0,0,5'b00000, 5'b10000,1,5));
    tab0.push_back(mk(0,0,0,5'b00000, 5'b00000,0,6));

    // MODE 1: fill, steady retire, stall, flush+stall, refill, drain
    tab1.push_back(mk(1,0,0,5'b00000, 5'b00000,0,0));
    tab1.push_back(mk(1,0,0,5'b00000, 5'b00001,0,0));
    tab1.push_back(mk(1,0,0,5'b00000, 5'b00011,0,0));
    tab1.push_back(mk(1,0,0,5'b00000, 5'b00111,0,0));
    tab1.push_back(mk(1,0,0,5'b00000, 5'b01111,0,0));
    for (int i = 0; i < 10; i++) tab1.push_back(mk(1,0,0,5'b00000, 5'b11111,1,i));
    tab1.push_back(mk(1,1,0,5'b00000, 5'b11111,0,10));
    tab1.push_back(mk(1,1,0,5'b00000, 5'b11111,0,10));
    tab1.push_back(mk(1,1,1,5'b00000, 5'b11111,0,10));
    tab1.push_back(mk(1,0,0,5'b00000, 5'b00000,0,10));
    tab1.push_back(mk(1,0,0,5'b11111, 5'b00001,0,10));
    tab1.push_back(mk(0,0,0,5'b11111, 5'b00011,0,10));
    tab1.push_back(mk(0,0,0,5'b11111, 5'b00110,0,10));
    tab1.push_back(mk(0,1,0,5'b00000, 5'b01100,0,10));
    tab1.push_back(mk(0,0,0,5'b00000, 5'b01100,0,10));
    tab1.push_back(mk(0,0,0,5'b00000, 5'b11000,1,10));
    tab1.push_back(mk(0,0,0,5'b00000, 5'b10000,1,11));
    tab1.push_back(mk(0,0,0,5'b00000, 5'b00000,0,12));

    drive(0, 0, 0, 0, 5'b00000);
    drive(1, 0, 0, 0, 5'b00000);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    observe(0, "reset m0", 5'b00000, 1'b0, 0);
    observe(1, "reset m1", 5'b00000, 1'b0, 0);

    run_table(0);

    // Reset mid-instruction wins over run
    drive(0, 1, 0, 0, 5'b00000);
    repeat (4) @(posedge clk);
    #1;
    chk("pre-reset stage_en", {27'd0, if0.stage_en}, 32'h08);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    observe(0, "mid reset", 5'b00000, 1'b0, 0);

    // Two-cycle instructions until the 4-bit counter wraps
    drive(0, 1, 0, 0, 5'b01110);
    repeat (32) @(posedge clk);
    #1;
    observe(0, "wrap pre", 5'b10000, 1'b1, 15);
    @(posedge clk);
    #1;
    observe(0, "wrap post", 5'b00001, 1'b0, 0);
    drive(0, 0, 0, 0, 5'b00000);

    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_table(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
